sys_out_fifo: RTL and testbench

- Buffers bytes written to the system output port by the processor.
- Sits directly downstream of the system-output selector: one push per `write` cycle targeting the system output (`write & ~instruction[3]`).
- Presents the bytes in order to an external consumer over a valid/ready handshake.
- The processor never stalls. Bytes that arrive while the buffer is full are dropped and recorded in a sticky overflow flag.

---
 rtl/sys_out_fifo.sv | 69 ++++++
 tb/tb_sys_out_fifo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sys_out_fifo.sv
// Output buffer for processor writes to the system output port.
// First-word fall-through FIFO; pushes that find it full are dropped and latch a sticky overflow flag.
module sys_out_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    assign out_valid = (count != '0);
    assign full      = (count == DEPTH_CNT);
    assign out_data  = mem[rd_ptr];

    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = wr_en & (~full | pop);
    assign drop = wr_en & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sys_out_fifo.sv
// Directed bench for sys_out_fifo: vector table with hand-computed results plus a wrap-around sequence.
module tb_sys_out_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       full;
    logic [2:0] count;
    logic       ovf;
    logic       ovf_clr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sys_out_fifo #(.AW(2), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .full      (full),
        .count     (count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic rd, logic c,
                                logic ev, logic [7:0] ed, logic [2:0] ec, logic ef, logic eo);
        vec_t v;
        v.rst = r; v.wr = w; v.din = d; v.rdy = rd; v.clr = c;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.eo = eo;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic w, logic [7:0] d, logic rd, logic c);
        rst = r; wr_en = w; wr_data = d; out_ready = rd; ovf_clr = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model[$];
    logic [7:0] nxt;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        #2;

        //                r  w  din   rdy clr   ev ed     ec  ef eo
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 0,   1, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0,   1, 8'h11, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0,   1, 8'h11, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0,   1, 8'h11, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0,   1, 8'h11, 4, 1, 0));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0,   1, 8'h11, 4, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   1, 8'h22, 3, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   1, 8'h33, 2, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   1, 8'h44, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   0, 8'h11, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   0, 8'h11, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,   0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0,   1, 8'h11, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0,   1, 8'h11, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0,   1, 8'h11, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0,   1, 8'h11, 4, 1, 0));
        vecs.push_back(mk(0, 1, 8'h66, 1, 0,   1, 8'h22, 4, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   1, 8'h33, 3, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   1, 8'h44, 2, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   1, 8'h66, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h77, 1, 0,   1, 8'h77, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h88, 0, 0,   1, 8'h77, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h99, 0, 0,   1, 8'h77, 3, 0, 0));
        vecs.push_back(mk(1, 1, 8'hAA, 1, 0,   0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 0, 0,   1, 8'h01, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0,   1, 8'h01, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 0,   1, 8'h01, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0,   1, 8'h01, 4, 1, 0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 1,   1, 8'h01, 4, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 8'h01, 4, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d {valid,data,count,full,ovf}", i),
                {19'b0, out_valid, out_data, count, full, ovf},
                {19'b0, vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].ef, vecs[i].eo});
        end

        // Wrap-around: 10 rounds of two pushes then two pops, checked against a queue model.
        nxt = 8'h01;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 2; k++) begin
                drive(0, 1, nxt, 0, 0);
                model.push_back(nxt);
                nxt = nxt + 8'h01;
                chk($sformatf("wrap r%0d push%0d count", r, k), 32'(count), 32'(k + 1));
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("wrap r%0d pop%0d valid", r, k), 32'(out_valid), 32'd1);
                chk($sformatf("wrap r%0d pop%0d data", r, k), 32'(out_data), 32'(model[0]));
                void'(model.pop_front());
                drive(0, 0, 8'h00, 1, 0);
            end
            chk($sformatf("wrap r%0d end count", r), 32'(count), 32'd0);
        end
        chk("wrap final valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
